io_write_buffer: RTL and testbench

IO_WRITE_BUFFER -- requirements
Module: io_write_buffer

---
 rtl/io_write_buffer_pkg.sv | 14 +
 rtl/io_write_buffer_fifo.sv | 50 +++++
 rtl/io_write_buffer.sv | 136 +++++++++++++
 tb/tb_io_write_buffer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_write_buffer_pkg.sv
// Shared constants and drain-state encoding for the IO write buffer.
package io_write_buffer_pkg;
    localparam logic [1:0] IO_HI   = 2'b11;
    localparam logic [2:0] IO_UART = 3'h0;
    localparam logic [2:0] IO_HALT = 3'h4;
    localparam int ENTRY_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_HALT
    } drain_state_e;
endpackage

// File: rtl/io_write_buffer_fifo.sv
// io_fifo: storage for queued IO writes, circular buffer with occupancy count.
module io_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 11,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
endmodule

// File: rtl/io_write_buffer.sv
// CPU-side write buffer: RAM pass-through, IO writes queued and drained to the UART port.
// Optional counters enabled by IO_WRITE_BUFFER_STATS_EN.
//
// state | meaning
// IDLE  | nothing in flight, IO reads may be forwarded when the queue is empty
// SEND  | head entry driven onto the IO port and popped
// GAP   | one bubble cycle between consecutive sends
// HALT  | halt byte sent; IO writes discarded forever
module io_write_buffer
    import io_write_buffer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        cpu_valid,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic        cpu_stall,
    output logic        ram_en,
    output logic [16:0] ram_a,
    output logic        ram_wr,
    output logic        io_en,
    output logic [2:0]  io_a,
    output logic [7:0]  io_dout,
    output logic        io_wr,
    input  logic        io_buffer_full,
`ifdef IO_WRITE_BUFFER_STATS_EN
    output logic [31:0] stat_sent,
    output logic [31:0] stat_stall,
`endif
    output logic        halted
);
    localparam int CW = $clog2(DEPTH + 1);

    drain_state_e       state_q, state_d;
    logic [CW-1:0]      count;
    logic [ENTRY_W-1:0] head;
    logic bus_ok, is_io, io_wr_acc, io_rd_acc, drop, full, empty;
    logic fwd_read, push, pop, stall_wr, stall_rd, unused_hi;

    assign unused_hi = ^cpu_a[31:18];
    assign bus_ok    = rdy_in & rst_in;
    assign is_io     = cpu_a[17:16] == IO_HI;
    assign io_wr_acc = cpu_valid & is_io & cpu_wr;
    assign io_rd_acc = cpu_valid & is_io & ~cpu_wr;
    assign drop      = (cpu_a[15:0] == {13'd0, IO_UART}) && (cpu_dout == 8'h00);
    assign full      = count == CW'(DEPTH);
    assign empty     = count == '0;
    assign halted    = state_q == ST_HALT;
    assign fwd_read  = io_rd_acc & empty & (state_q == ST_IDLE);
    assign push      = bus_ok & io_wr_acc & ~drop & ~halted & ~full;
    assign stall_wr  = io_wr_acc & ~drop & ~halted & full;
    assign stall_rd  = io_rd_acc & ~fwd_read;
    assign pop       = bus_ok & (state_q == ST_SEND) & ~fwd_read;

    io_fifo #(.DEPTH(DEPTH), .W(ENTRY_W), .CW(CW)) u_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (push),
        .push_data ({cpu_a[2:0], cpu_dout}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    always_comb begin
        ram_en    = 1'b0;
        ram_wr    = 1'b0;
        ram_a     = '0;
        io_en     = 1'b0;
        io_wr     = 1'b0;
        io_a      = '0;
        io_dout   = '0;
        cpu_stall = 1'b0;
        if (bus_ok) begin
            ram_en    = cpu_valid & ~is_io;
            ram_wr    = cpu_valid & ~is_io & cpu_wr;
            ram_a     = cpu_a[16:0];
            cpu_stall = stall_wr | stall_rd;
            // A forwarded read owns the IO port; a pending send waits a cycle.
            if (fwd_read) begin
                io_en = 1'b1;
                io_a  = cpu_a[2:0];
            end else if (state_q == ST_SEND) begin
                io_en   = 1'b1;
                io_wr   = 1'b1;
                io_a    = head[10:8];
                io_dout = head[7:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!empty && !io_buffer_full) state_d = ST_SEND;
            ST_SEND: if (pop) state_d = (head[10:8] == IO_HALT) ? ST_HALT : ST_GAP;
            ST_GAP:  state_d = (!empty && !io_buffer_full) ? ST_SEND : ST_IDLE;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
        if (!rdy_in) state_d = state_q;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

`ifdef IO_WRITE_BUFFER_STATS_EN
    logic [31:0] stat_sent_q, stat_sent_d, stat_stall_q, stat_stall_d;

    always_comb begin
        stat_sent_d  = stat_sent_q;
        stat_stall_d = stat_stall_q;
        if (pop && stat_sent_q != '1)        stat_sent_d  = stat_sent_q + 32'd1;
        if (cpu_stall && stat_stall_q != '1) stat_stall_d = stat_stall_q + 32'd1;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            stat_sent_q  <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_sent_q  <= stat_sent_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_sent  = stat_sent_q;
    assign stat_stall = stat_stall_q;
`endif
endmodule

// File: tb/tb_io_write_buffer.sv
// Directed bench for io_write_buffer: pass-through, queueing, drain timing, stalls and halt.
module tb_io_write_buffer;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, cpu_valid, cpu_wr, io_buffer_full;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_stall, ram_en, ram_wr, io_en, io_wr, halted;
    logic [16:0] ram_a;
    logic [2:0]  io_a;
    logic [7:0]  io_dout;
`ifdef IO_WRITE_BUFFER_STATS_EN
    logic [31:0] stat_sent, stat_stall;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int          log_cyc[$];
    logic [10:0] log_dat[$];

    io_write_buffer #(.DEPTH(8)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .cpu_valid      (cpu_valid),
        .cpu_a          (cpu_a),
        .cpu_dout       (cpu_dout),
        .cpu_wr         (cpu_wr),
        .cpu_stall      (cpu_stall),
        .ram_en         (ram_en),
        .ram_a          (ram_a),
        .ram_wr         (ram_wr),
        .io_en          (io_en),
        .io_a           (io_a),
        .io_dout        (io_dout),
        .io_wr          (io_wr),
        .io_buffer_full (io_buffer_full),
`ifdef IO_WRITE_BUFFER_STATS_EN
        .stat_sent      (stat_sent),
        .stat_stall     (stat_stall),
`endif
        .halted         (halted)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (rst_in && io_en && io_wr) begin
            log_cyc.push_back(cyc);
            log_dat.push_back({io_a, io_dout});
        end
    end

    task automatic idle_bus();
        cpu_valid = 1'b0;
        cpu_wr    = 1'b0;
        cpu_a     = 32'h0;
        cpu_dout  = 8'h00;
    endtask

    task automatic drive(input logic wr, input logic [31:0] a, input logic [7:0] d);
        cpu_valid = 1'b1;
        cpu_wr    = wr;
        cpu_a     = a;
        cpu_dout  = d;
    endtask

    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic to_sample();
        @(negedge clk_in);
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        rdy_in = 1'b1;
        io_buffer_full = 1'b0;
        drive(1'b1, 32'h0000_0100, 8'h5A);
        #1;
        checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL reset_ram_en: got %0b want 0", ram_en); end
        checks++; if (ram_wr !== 1'b0) begin errors++; $display("FAIL reset_ram_wr: got %0b want 0", ram_wr); end
        checks++; if (io_en !== 1'b0) begin errors++; $display("FAIL reset_io_en: got %0b want 0", io_en); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", cpu_stall); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b want 0", halted); end
        repeat (3) next_cycle();
        idle_bus();
        rst_in = 1'b1;
    endtask

    task automatic test_ram_passthrough();
        next_cycle();
        drive(1'b1, 32'h0000_0100, 8'h5A);
        to_sample();
        checks++; if (ram_en !== 1'b1) begin errors++; $display("FAIL ram_en: got %0b want 1", ram_en); end
        checks++; if (ram_wr !== 1'b1) begin errors++; $display("FAIL ram_wr: got %0b want 1", ram_wr); end
        checks++; if (ram_a !== 17'h00100) begin errors++; $display("FAIL ram_a: got %h want 00100", ram_a); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL ram_stall: got %0b want 0", cpu_stall); end
        checks++; if (io_en !== 1'b0) begin errors++; $display("FAIL ram_io_en: got %0b want 0", io_en); end
        rdy_in = 1'b0;
        #1;
        checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL freeze_ram_en: got %0b want 0", ram_en); end
        next_cycle();
        rdy_in = 1'b1;
        idle_bus();
    endtask

    task automatic test_drop_null();
        log_cyc.delete(); log_dat.delete();
        next_cycle();
        drive(1'b1, 32'h0003_0000, 8'h00);
        to_sample();
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL drop_stall: got %0b want 0", cpu_stall); end
        next_cycle();
        idle_bus();
        checks++; if (dut.u_fifo.count !== 4'd0) begin errors++; $display("FAIL drop_count: got %0d want 0", dut.u_fifo.count); end
        repeat (5) next_cycle();
        checks++; if (log_dat.size() != 0) begin errors++; $display("FAIL drop_io_wr: got %0d writes want 0", log_dat.size()); end
    endtask

    task automatic test_two_bytes();
        log_cyc.delete(); log_dat.delete();
        next_cycle();
        drive(1'b1, 32'h0003_0000, 8'h41);
        next_cycle();
        drive(1'b1, 32'h0003_0000, 8'h42);
        next_cycle();
        idle_bus();
        repeat (8) next_cycle();
        checks++; if (log_dat.size() != 2) begin errors++; $display("FAIL ab_count: got %0d want 2", log_dat.size()); end
        if (log_dat.size() == 2) begin
            checks++; if (log_dat[0] !== 11'h041) begin errors++; $display("FAIL ab_first: got %h want 041", log_dat[0]); end
            checks++; if (log_dat[1] !== 11'h042) begin errors++; $display("FAIL ab_second: got %h want 042", log_dat[1]); end
            checks++; if (log_cyc[1] - log_cyc[0] != 2) begin errors++; $display("FAIL ab_gap: got %0d want 2", log_cyc[1] - log_cyc[0]); end
        end
    endtask

    task automatic test_full_stall();
        int stalled;
        int k;
        log_cyc.delete(); log_dat.delete();
        io_buffer_full = 1'b1;
        for (int i = 0; i < 9; i++) begin
            next_cycle();
            drive(1'b1, 32'h0003_0000, 8'(i + 1));
            to_sample();
            checks++; if (cpu_stall !== (i == 8)) begin errors++; $display("FAIL fill_stall_%0d: got %0b want %0b", i, cpu_stall, (i == 8)); end
        end
        repeat (2) begin
            next_cycle();
            to_sample();
            checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL full_hold: got %0b want 1", cpu_stall); end
        end
        next_cycle();
        io_buffer_full = 1'b0;
        stalled = 0;
        for (k = 0; k < 10; k++) begin
            to_sample();
            if (!cpu_stall) break;
            stalled++;
            next_cycle();
        end
        checks++; if (k == 10) begin errors++; $display("FAIL full_release_timeout: still stalled after %0d cycles want release", k); end
        checks++; if (stalled != 2) begin errors++; $display("FAIL full_release_cycles: got %0d want 2", stalled); end
        next_cycle();
        idle_bus();
        repeat (30) next_cycle();
        checks++; if (log_dat.size() != 9) begin errors++; $display("FAIL full_drain_count: got %0d want 9", log_dat.size()); end
        if (log_dat.size() == 9) begin
            for (int i = 0; i < 9; i++) begin
                checks++; if (log_dat[i] !== {3'd0, 8'(i + 1)}) begin errors++; $display("FAIL full_order_%0d: got %h want %h", i, log_dat[i], {3'd0, 8'(i + 1)}); end
            end
        end
    endtask

    task automatic test_read_stall();
        int stalled;
        int k;
        log_cyc.delete(); log_dat.delete();
        next_cycle();
        drive(1'b1, 32'h0003_0000, 8'h58);
        next_cycle();
        drive(1'b0, 32'h0003_0004, 8'h00);
        stalled = 0;
        for (k = 0; k < 12; k++) begin
            to_sample();
            if (!cpu_stall) break;
            stalled++;
            next_cycle();
        end
        checks++; if (k == 12) begin errors++; $display("FAIL rd_timeout: still stalled after %0d cycles want release", k); end
        checks++; if (stalled != 3) begin errors++; $display("FAIL rd_stall_cycles: got %0d want 3", stalled); end
        checks++; if (io_en !== 1'b1) begin errors++; $display("FAIL rd_io_en: got %0b want 1", io_en); end
        checks++; if (io_wr !== 1'b0) begin errors++; $display("FAIL rd_io_wr: got %0b want 0", io_wr); end
        checks++; if (io_a !== 3'h4) begin errors++; $display("FAIL rd_io_a: got %h want 4", io_a); end
        next_cycle();
        idle_bus();
        checks++; if (log_dat.size() != 1) begin errors++; $display("FAIL rd_sent_count: got %0d want 1", log_dat.size()); end
        if (log_dat.size() == 1) begin
            checks++; if (log_dat[0] !== 11'h058) begin errors++; $display("FAIL rd_sent_byte: got %h want 058", log_dat[0]); end
        end
    endtask

    task automatic test_halt();
        int z_seen;
        log_cyc.delete(); log_dat.delete();
        next_cycle();
        drive(1'b1, 32'h0003_0004, 8'h11);
        next_cycle();
        drive(1'b1, 32'h0003_0000, 8'h5A);
        to_sample();
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_early: got %0b want 0", halted); end
        next_cycle();
        idle_bus();
        to_sample();
        checks++; if (io_wr !== 1'b1 || io_a !== 3'h4) begin errors++; $display("FAIL halt_send: got wr=%0b a=%h want wr=1 a=4", io_wr, io_a); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_during_send: got %0b want 0", halted); end
        next_cycle();
        to_sample();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_set: got %0b want 1", halted); end
        next_cycle();
        drive(1'b1, 32'h0003_0000, 8'h5A);
        to_sample();
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL halt_discard_stall: got %0b want 0", cpu_stall); end
        next_cycle();
        drive(1'b1, 32'h0000_0200, 8'h33);
        to_sample();
        checks++; if (ram_en !== 1'b1) begin errors++; $display("FAIL halt_ram_en: got %0b want 1", ram_en); end
        next_cycle();
        idle_bus();
        repeat (5) next_cycle();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %0b want 1", halted); end
        z_seen = 0;
        foreach (log_dat[i]) if (log_dat[i][7:0] == 8'h5A) z_seen++;
        checks++; if (z_seen != 0) begin errors++; $display("FAIL halt_z_sent: got %0d want 0", z_seen); end
        checks++; if (log_dat.size() != 1) begin errors++; $display("FAIL halt_sent_count: got %0d want 1", log_dat.size()); end
        rst_in = 1'b0;
        #1;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_reset: got %0b want 0", halted); end
        checks++; if (dut.u_fifo.count !== 4'd0) begin errors++; $display("FAIL halt_reset_count: got %0d want 0", dut.u_fifo.count); end
        next_cycle();
        rst_in = 1'b1;
        repeat (6) next_cycle();
        checks++; if (log_dat.size() != 1) begin errors++; $display("FAIL reset_discard: got %0d writes want 1", log_dat.size()); end
    endtask

    initial begin
        idle_bus();
        rst_in = 1'b0;
        rdy_in = 1'b1;
        io_buffer_full = 1'b0;
        test_reset();
        test_ram_passthrough();
        test_drop_null();
        test_two_bytes();
        test_full_stall();
        test_read_stall();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
